// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: control/data in, scanned segments out.
interface seg7_scan_driver_if;
  logic        en;
  logic        load;
  logic [31:0] data;
  logic [7:0]  blank_mask;
  logic [7:0]  dp;
  logic [7:0]  seg_74;
  logic [7:0]  seg_30;
  logic [7:0]  tub_sel;

  // Producer of the display word and consumer of the scan outputs.
  modport master (
    output en, load, data, blank_mask, dp,
    input  seg_74, seg_30, tub_sel
  );

  // The scan driver itself.
  modport slave (
    input  en, load, data, blank_mask, dp,
    output seg_74, seg_30, tub_sel
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Eight-digit 7-segment scan driver: two 4-digit banks scanned in parallel, with the
// display word committed only at frame boundaries so a scan never mixes old and new data.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input logic               clk,
  input logic               rstn,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMax = PW'(SCAN_DIV - 1);

  logic [PW-1:0] r_presc, w_presc_d;
  logic [1:0]    r_index, w_index_d;
  logic [31:0]   r_pend_data, w_pend_data_d;
  logic          r_pend, w_pend_d;
  logic [31:0]   r_disp, w_disp_d;
  logic [7:0]    r_seg_74, r_seg_30, r_tub_sel;
  logic [7:0]    w_seg_74_d, w_seg_30_d, w_tub_sel_d;

  logic          w_tick;
  logic          w_frame;
  logic [2:0]    w_lo_sel, w_hi_sel;
  logic [3:0]    w_lo_nib, w_hi_nib;

  // Hex nibble to {a,b,c,d,e,f,g,dp}; dp bit left clear here.
  function automatic logic [7:0] dec7(input logic [3:0] n);
    logic [7:0] s;
    unique case (n)
      4'h0: s = 8'hFC;
      4'h1: s = 8'h60;
      4'h2: s = 8'hDA;
      4'h3: s = 8'hF2;
      4'h4: s = 8'h66;
      4'h5: s = 8'hB6;
      4'h6: s = 8'hBE;
      4'h7: s = 8'hE0;
      4'h8: s = 8'hFE;
      4'h9: s = 8'hF6;
      4'hA: s = 8'hEE;
      4'hB: s = 8'h3E;
      4'hC: s = 8'h9C;
      4'hD: s = 8'h7A;
      4'hE: s = 8'h9E;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign w_tick  = bus.en && (r_presc == PMax);
  assign w_frame = w_tick && (r_index == 2'd3);

  // Next state of the scan counters and the pending/display word pair.
  always_comb begin
    w_presc_d     = r_presc;
    w_index_d     = r_index;
    w_pend_data_d = r_pend_data;
    w_pend_d      = r_pend;
    w_disp_d      = r_disp;

    if (!bus.en) begin
      w_presc_d = '0;
      w_index_d = 2'd0;
    end else if (w_tick) begin
      w_presc_d = '0;
      w_index_d = r_index + 2'd1;
    end else begin
      w_presc_d = r_presc + PW'(1);
    end

    if (bus.load) begin
      w_pend_data_d = bus.data;
      // With the scan stopped, or exactly on the boundary, there is no frame to protect.
      if (!bus.en || w_frame) begin
        w_disp_d = bus.data;
        w_pend_d = 1'b0;
      end else begin
        w_pend_d = 1'b1;
      end
    end else if (w_frame && r_pend) begin
      w_disp_d = r_pend_data;
      w_pend_d = 1'b0;
    end
  end

  // Segment/digit-select values for the slot currently indexed, both banks at once.
  always_comb begin
    w_lo_sel    = {1'b0, r_index};
    w_hi_sel    = {1'b1, r_index};
    w_lo_nib    = r_disp[{r_index, 2'b00} +: 4];
    w_hi_nib    = r_disp[{1'b1, r_index, 2'b00} +: 4];
    w_tub_sel_d = 8'h11 << r_index;
    w_seg_30_d  = dec7(w_lo_nib) | {7'b0, bus.dp[w_lo_sel]};
    w_seg_74_d  = dec7(w_hi_nib) | {7'b0, bus.dp[w_hi_sel]};
    // Blanked digits keep their tub_sel bit; only the segments go dark.
    if (bus.blank_mask[w_lo_sel]) w_seg_30_d = 8'h00;
    if (bus.blank_mask[w_hi_sel]) w_seg_74_d = 8'h00;
  end

  // Scan and data state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_presc     <= '0;
      r_index     <= 2'd0;
      r_pend_data <= '0;
      r_pend      <= 1'b0;
      r_disp      <= '0;
    end else begin
      r_presc     <= w_presc_d;
      r_index     <= w_index_d;
      r_pend_data <= w_pend_data_d;
      r_pend      <= w_pend_d;
      r_disp      <= w_disp_d;
    end
  end

  // Registered outputs; disabled display drives everything low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_seg_74  <= 8'h00;
      r_seg_30  <= 8'h00;
      r_tub_sel <= 8'h00;
    end else if (!bus.en) begin
      r_seg_74  <= 8'h00;
      r_seg_30  <= 8'h00;
      r_tub_sel <= 8'h00;
    end else begin
      r_seg_74  <= w_seg_74_d;
      r_seg_30  <= w_seg_30_d;
      r_tub_sel <= w_tub_sel_d;
    end
  end

  assign bus.seg_74  = r_seg_74;
  assign bus.seg_30  = r_seg_30;
  assign bus.tub_sel = r_tub_sel;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a behavioural model queues the expected {tub_sel,seg_74,seg_30}
// for each edge as stimulus is driven; the value is popped and compared after the edge.
module tb_seg7_scan_driver;
  localparam int unsigned Div = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  seg7_scan_driver_if bus_if ();

  seg7_scan_driver #(.SCAN_DIV(Div)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] dec_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                               8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  int          m_cnt;
  logic [1:0]  m_idx;
  logic [31:0] m_disp, m_preg;
  logic        m_pend;

  logic [23:0] exp_q [$];
  string       tag_q [$];

  function automatic logic [7:0] exp_seg(input logic [3:0] n, input logic b, input logic d);
    return b ? 8'h00 : (dec_tab[n] | {7'b0, d});
  endfunction

  // Expected outputs after the coming edge, from the pre-edge model state.
  function automatic logic [23:0] model_out();
    int k;
    logic [7:0] tub, s30, s74;
    if (!bus_if.en) return 24'h0;
    k   = int'(m_idx);
    tub = 8'h11 << k;
    s30 = exp_seg(m_disp[4*k +: 4], bus_if.blank_mask[k], bus_if.dp[k]);
    s74 = exp_seg(m_disp[16+4*k +: 4], bus_if.blank_mask[k+4], bus_if.dp[k+4]);
    return {tub, s74, s30};
  endfunction

  task automatic model_edge();
    logic tick, fb;
    tick = bus_if.en && (m_cnt == Div - 1);
    fb   = tick && (m_idx == 2'd3);
    if (bus_if.load) begin
      m_preg = bus_if.data;
      if (!bus_if.en || fb) begin
        m_disp = bus_if.data;
        m_pend = 1'b0;
      end else begin
        m_pend = 1'b1;
      end
    end else if (fb && m_pend) begin
      m_disp = m_preg;
      m_pend = 1'b0;
    end
    if (!bus_if.en) begin
      m_cnt = 0;
      m_idx = 2'd0;
    end else if (tick) begin
      m_cnt = 0;
      m_idx = m_idx + 2'd1;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_idx  = 2'd0;
    m_disp = '0;
    m_preg = '0;
    m_pend = 1'b0;
  endtask

  task automatic step(input string tag);
    logic [23:0] got, e;
    string t;
    exp_q.push_back(model_out());
    tag_q.push_back(tag);
    model_edge();
    @(posedge clk);
    #1;
    got = {bus_if.tub_sel, bus_if.seg_74, bus_if.seg_30};
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    checks++;
    assert (got === e) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", t, got, e);
    end
  endtask

  task automatic steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic step_load(input logic [31:0] d, input string tag);
    bus_if.data = d;
    bus_if.load = 1'b1;
    step(tag);
    bus_if.load = 1'b0;
  endtask

  task automatic check_now(input string tag, input logic [23:0] e);
    logic [23:0] got;
    got = {bus_if.tub_sel, bus_if.seg_74, bus_if.seg_30};
    checks++;
    assert (got === e) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, e);
    end
  endtask

  // Advance until the model's pre-edge state is (idx, cnt); bounded.
  task automatic step_until(input logic [1:0] idx, input int cnt, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (m_idx == idx && m_cnt == cnt) begin
        found = 1'b1;
        break;
      end
      step(tag);
    end
    checks++;
    assert (found) else begin
      failures++;
      $error("FAIL %s_align got=0 exp=1", tag);
    end
  endtask

  initial begin
    rstn              = 1'b0;
    bus_if.en         = 1'b0;
    bus_if.load       = 1'b0;
    bus_if.data       = '0;
    bus_if.blank_mask = '0;
    bus_if.dp         = '0;
    model_reset();
    #12;
    check_now("reset", 24'h0);
    rstn = 1'b1;

    // First word goes pending; first frame shows zeros.
    bus_if.en = 1'b1;
    step_load(32'h7654_3210, "load0");
    check_now("first_slot", 24'h11_FC_FC);
    steps(16, "frame1");
    check_now("f2_k0", 24'h11_66_FC);
    steps(12, "frame2");
    check_now("f2_k3", 24'h88_E0_F2);

    // Full decode table across two words.
    step_load(32'h89AB_CDEF, "load_hi");
    steps(32, "dec_hi");
    step_load(32'h0123_4567, "load_lo");
    steps(32, "dec_lo");

    // Mid-frame load at index 1.
    step_until(2'd1, 1, "to_k1");
    step_load(32'hFFFF_FFFF, "load_mid");
    steps(20, "mid_frame");

    // Load exactly on the boundary cycle: bypass to display.
    step_until(2'd3, Div - 1, "to_bnd");
    step_load(32'h2468_ACE0, "load_bnd");
    check_now("bnd_last", 24'h88_8E_8E);
    step("bnd_k0");
    check_now("bnd_k0_const", 24'h11_FE_FC);
    steps(15, "bnd_frame");

    // Blanking and decimal point.
    bus_if.blank_mask = 8'hF0;
    bus_if.dp         = 8'h01;
    step_load(32'h0000_0000, "load_zero");
    steps(20, "blank");
    step_until(2'd0, 0, "to_k0");
    step("blank_k0");
    check_now("blank_k0_const", 24'h11_00_FD);
    steps(16, "blank_frame");
    bus_if.blank_mask = 8'h00;
    bus_if.dp         = 8'h00;

    // Disable mid-scan, load while disabled, re-enable.
    step_until(2'd2, 1, "to_k2");
    bus_if.en = 1'b0;
    step("en_off");
    check_now("en_off_const", 24'h0);
    step_load(32'h1111_1111, "load_dis");
    bus_if.en = 1'b1;
    step("en_on");
    check_now("en_on_const", 24'h11_60_60);
    steps(8, "en_run");

    // Reset mid-frame with pending data.
    step_until(2'd1, 0, "to_k1b");
    step_load(32'hABCD_EF01, "load_pend");
    steps(2, "pend");
    #2;
    rstn = 1'b0;
    #1;
    check_now("rst_async", 24'h0);
    model_reset();
    #2;
    rstn = 1'b1;
    steps(40, "post_rst");
    check_now("post_rst_const", 24'h22_FC_FC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
